pipelined_control_unit: RTL and testbench

- Successor to the single-cycle opcode decoder.
- Decodes an OPCODE_W-bit opcode in ID into the control bundle {wbs, wme, mm, ALUop, ri, wre}.
- Carries the bundle through ID/EX, EX/MEM and MEM/WB registers with valid bits.
- Adds load-use hazard stall, branch flush with pending capture, and freeze on memory wait. Sits between the decode stage and the datapath pipeline registers.

---
 rtl/cpu_ctrl_pkg.sv | 46 ++++
 rtl/ctrl_decoder.sv | 57 +++++
 rtl/pipelined_control_unit.sv | 157 +++++++++++++++
 tb/tb_pipelined_control_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_ctrl_pkg : opcodes, control bundle type and decode helpers     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_ctrl_pkg;

  localparam int ALUOP_BITS = 2;
  localparam int RI_BITS    = 2;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_BNE   = 4'h5;
  localparam logic [3:0] OP_BLT   = 4'h6;
  localparam logic [3:0] OP_BGE   = 4'h7;
  localparam logic [3:0] OP_LI    = 4'h8;
  localparam logic [3:0] OP_LOAD  = 4'h9;
  localparam logic [3:0] OP_STORE = 4'hA;

  typedef struct packed {
    logic                  wbs;
    logic                  wme;
    logic                  mm;
    logic [ALUOP_BITS-1:0] aluop;
    logic [RI_BITS-1:0]    ri;
    logic                  wre;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

  function automatic logic op_is_load(input logic [3:0] op);
    return op == OP_LOAD;
  endfunction

  // Only the ALU and compare/branch groups read rs2 as a register.
  function automatic logic op_reads_rs2(input logic [3:0] op);
    return op <= OP_BGE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decoder.sv
// +--------------------------------------------------------------------+
// | ctrl_decoder : combinational opcode -> control bundle + illegal    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module ctrl_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_bundle_t        ctrl,
  output logic                illegal
);

  logic [3:0] w_op_lo;
  logic       w_hi_zero;

  assign w_op_lo   = opcode[3:0];
  assign w_hi_zero = (opcode >> 4) == '0;

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    if (!w_hi_zero) begin
      illegal = 1'b1;
    end else begin
      case (w_op_lo)
        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
          ctrl.wbs   = 1'b1;
          ctrl.mm    = 1'b1;
          ctrl.aluop = w_op_lo[1:0];
          ctrl.wre   = 1'b1;
        end
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE: ctrl.ri = 2'b11;
        OP_LI: begin
          ctrl.wbs = 1'b1;
          ctrl.ri  = 2'b10;
          ctrl.wre = 1'b1;
        end
        OP_LOAD: begin
          ctrl.ri  = 2'b10;
          ctrl.wre = 1'b1;
        end
        OP_STORE: begin
          ctrl.wme = 1'b1;
          ctrl.ri  = 2'b10;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipelined_control_unit.sv
// +--------------------------------------------------------------------+
// | pipelined_control_unit : ID decode carried through EX/MEM/WB with  |
// | load-use stall, branch flush and memory-wait freeze.  Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module pipelined_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 2,
  parameter int RI_W     = 2,
  parameter int REG_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                flush,
  input  logic                mem_ready,
  output logic                stall,
  output logic                illegal,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [RI_W-1:0]     ex_ri,
  output logic                mem_wme,
  output logic                mem_mm,
  output logic                wb_wbs,
  output logic                wb_wre,
  output logic [REG_W-1:0]    wb_rd
);

  ctrl_bundle_t w_dec_ctrl;
  logic         w_dec_illegal;

  ctrl_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode  (id_opcode),
    .ctrl    (w_dec_ctrl),
    .illegal (w_dec_illegal)
  );

  logic             ex_valid_q, ex_valid_d, ex_is_load_q, ex_is_load_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d;
  ctrl_bundle_t     ex_ctrl_q, ex_ctrl_d;
  logic             mem_valid_q, mem_valid_d, mem_is_load_q, mem_is_load_d;
  logic             mem_wbs_q, mem_wbs_d, mem_wme_q, mem_wme_d;
  logic             mem_mm_q, mem_mm_d, mem_wre_q, mem_wre_d;
  logic [REG_W-1:0] mem_rd_q, mem_rd_d;
  logic             wb_valid_q, wb_valid_d, wb_wbs_q, wb_wbs_d, wb_wre_q, wb_wre_d;
  logic [REG_W-1:0] wb_rd_q, wb_rd_d;
  logic             pending_flush_q, pending_flush_d;

  logic w_freeze, w_kill, w_load_use, w_id_is_load, w_id_reads_rs2, w_ex_load;

  // A legal opcode guarantees the bits above the low nibble are zero.
  assign w_id_is_load   = ~w_dec_illegal & op_is_load(id_opcode[3:0]);
  assign w_id_reads_rs2 = ~w_dec_illegal & op_reads_rs2(id_opcode[3:0]);

  assign w_freeze   = mem_valid_q & (mem_wme_q | mem_is_load_q) & ~mem_ready;
  assign w_kill     = flush | pending_flush_q;
  assign w_load_use = ex_valid_q & ex_is_load_q & id_valid &
                      ((ex_rd_q == id_rs1) | ((ex_rd_q == id_rs2) & w_id_reads_rs2));
  assign w_ex_load  = id_valid & ~w_dec_illegal & ~w_kill & ~w_load_use;

  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_is_load_d    = ex_is_load_q;
    ex_rd_d         = ex_rd_q;
    ex_ctrl_d       = ex_ctrl_q;
    mem_valid_d     = mem_valid_q;
    mem_is_load_d   = mem_is_load_q;
    mem_wbs_d       = mem_wbs_q;
    mem_wme_d       = mem_wme_q;
    mem_mm_d        = mem_mm_q;
    mem_wre_d       = mem_wre_q;
    mem_rd_d        = mem_rd_q;
    wb_valid_d      = wb_valid_q;
    wb_wbs_d        = wb_wbs_q;
    wb_wre_d        = wb_wre_q;
    wb_rd_d         = wb_rd_q;
    pending_flush_d = pending_flush_q;
    if (w_freeze) begin
      pending_flush_d = pending_flush_q | flush;
    end else begin
      pending_flush_d = 1'b0;
      wb_valid_d      = mem_valid_q;
      wb_wbs_d        = mem_wbs_q;
      wb_wre_d        = mem_wre_q;
      wb_rd_d         = mem_rd_q;
      mem_valid_d     = ex_valid_q;
      mem_is_load_d   = ex_is_load_q;
      mem_wbs_d       = ex_ctrl_q.wbs;
      mem_wme_d       = ex_ctrl_q.wme;
      mem_mm_d        = ex_ctrl_q.mm;
      mem_wre_d       = ex_ctrl_q.wre;
      mem_rd_d        = ex_rd_q;
      // Flush, load-use, invalid and illegal all inject the same bubble.
      ex_valid_d      = w_ex_load;
      ex_is_load_d    = w_ex_load & w_id_is_load;
      ex_rd_d         = w_ex_load ? id_rd : '0;
      ex_ctrl_d       = w_ex_load ? w_dec_ctrl : CTRL_NOP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_is_load_q    <= 1'b0;
      ex_rd_q         <= '0;
      ex_ctrl_q       <= CTRL_NOP;
      mem_valid_q     <= 1'b0;
      mem_is_load_q   <= 1'b0;
      mem_wbs_q       <= 1'b0;
      mem_wme_q       <= 1'b0;
      mem_mm_q        <= 1'b0;
      mem_wre_q       <= 1'b0;
      mem_rd_q        <= '0;
      wb_valid_q      <= 1'b0;
      wb_wbs_q        <= 1'b0;
      wb_wre_q        <= 1'b0;
      wb_rd_q         <= '0;
      pending_flush_q <= 1'b0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_is_load_q    <= ex_is_load_d;
      ex_rd_q         <= ex_rd_d;
      ex_ctrl_q       <= ex_ctrl_d;
      mem_valid_q     <= mem_valid_d;
      mem_is_load_q   <= mem_is_load_d;
      mem_wbs_q       <= mem_wbs_d;
      mem_wme_q       <= mem_wme_d;
      mem_mm_q        <= mem_mm_d;
      mem_wre_q       <= mem_wre_d;
      mem_rd_q        <= mem_rd_d;
      wb_valid_q      <= wb_valid_d;
      wb_wbs_q        <= wb_wbs_d;
      wb_wre_q        <= wb_wre_d;
      wb_rd_q         <= wb_rd_d;
      pending_flush_q <= pending_flush_d;
    end
  end

  assign stall    = w_freeze | (w_load_use & ~w_kill);
  assign illegal  = id_valid & w_dec_illegal;
  assign ex_aluop = ex_valid_q ? ex_ctrl_q.aluop : '0;
  assign ex_ri    = ex_valid_q ? ex_ctrl_q.ri : '0;
  assign mem_wme  = mem_valid_q & mem_wme_q;
  assign mem_mm   = mem_valid_q & mem_mm_q;
  assign wb_wbs   = wb_valid_q & wb_wbs_q;
  assign wb_wre   = wb_valid_q & wb_wre_q;
  assign wb_rd    = wb_valid_q ? wb_rd_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
// +--------------------------------------------------------------------+
// | tb_pipelined_control_unit : directed + random stimulus against a   |
// | behavioural pipeline model.  Rev 1.0                               |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pipelined_control_unit;

  logic       clk, rst, id_valid, flush, mem_ready;
  logic [3:0] id_opcode, id_rs1, id_rs2, id_rd;
  logic       stall, illegal, mem_wme, mem_mm, wb_wbs, wb_wre;
  logic [1:0] ex_aluop, ex_ri;
  logic [3:0] wb_rd;

  pipelined_control_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
    .mem_ready(mem_ready), .stall(stall), .illegal(illegal),
    .ex_aluop(ex_aluop), .ex_ri(ex_ri), .mem_wme(mem_wme), .mem_mm(mem_mm),
    .wb_wbs(wb_wbs), .wb_wre(wb_wre), .wb_rd(wb_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit v; int op; int rd; } slot_t;
  slot_t m_ex, m_mem, m_wb;
  bit    m_pend;
  bit    last_stall;
  int    total = 0;
  int    bad   = 0;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // {wbs, wme, mm, aluop[1:0], ri[1:0], wre}
  function automatic bit [7:0] spec_ctrl(input int op);
    bit [1:0] lo;
    lo = op[1:0];
    if (op < 4)   return {3'b101, lo, 2'b00, 1'b1};
    if (op < 8)   return {3'b000, 2'b00, 2'b11, 1'b0};
    if (op == 8)  return {3'b100, 2'b00, 2'b10, 1'b1};
    if (op == 9)  return {3'b000, 2'b00, 2'b10, 1'b1};
    if (op == 10) return {3'b010, 2'b00, 2'b10, 1'b0};
    return 8'h00;
  endfunction

  task automatic model_clear();
    m_ex = '{0, 0, 0}; m_mem = '{0, 0, 0}; m_wb = '{0, 0, 0}; m_pend = 0; last_stall = 0;
  endtask

  task automatic check_regs();
    bit [7:0] ce, cm, cw;
    ce = m_ex.v  ? spec_ctrl(m_ex.op)  : 8'h00;
    cm = m_mem.v ? spec_ctrl(m_mem.op) : 8'h00;
    cw = m_wb.v  ? spec_ctrl(m_wb.op)  : 8'h00;
    check_val("ex_aluop", ex_aluop, ce[4:3]);
    check_val("ex_ri",    ex_ri,    ce[2:1]);
    check_val("mem_wme",  mem_wme,  cm[6]);
    check_val("mem_mm",   mem_mm,   cm[5]);
    check_val("wb_wbs",   wb_wbs,   cw[7]);
    check_val("wb_wre",   wb_wre,   cw[0]);
    check_val("wb_rd",    wb_rd,    m_wb.v ? m_wb.rd : 0);
  endtask

  task automatic step(input bit v, input int op, input int rs1, input int rs2,
                      input int rd, input bit fl, input bit mr);
    bit frz, kill, lu, legal, exp_stall;
    @(negedge clk);
    check_regs();
    id_valid = v; id_opcode = op[3:0]; id_rs1 = rs1[3:0]; id_rs2 = rs2[3:0];
    id_rd = rd[3:0]; flush = fl; mem_ready = mr;
    #1;
    legal     = (op <= 10);
    frz       = m_mem.v && (m_mem.op == 9 || m_mem.op == 10) && !mr;
    kill      = fl || m_pend;
    lu        = m_ex.v && m_ex.op == 9 && v &&
                (m_ex.rd == rs1 || (m_ex.rd == rs2 && op < 8));
    exp_stall = frz || (lu && !kill);
    check_val("stall",   stall,   exp_stall);
    check_val("illegal", illegal, v && !legal);
    last_stall = exp_stall;
    @(posedge clk);
    if (frz) begin
      m_pend = m_pend || fl;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      if (v && legal && !kill && !lu) m_ex = '{1, op, rd};
      else                            m_ex = '{0, 0, 0};
      m_pend = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; id_valid = 0; id_opcode = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    flush = 0; mem_ready = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_regs();
    check_val("rst_stall", stall, 0);
  endtask

  initial begin
    bit v, fl, mr;
    int op, rs1, rs2, rd, r;
    v = 0; op = 0; rs1 = 0; rs2 = 0; rd = 0;
    do_reset();

    // Basic latency: AND to r3.
    step(1, 2, 0, 0, 3, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 1);

    // Load-use on rs1; the stalled add is re-presented.
    step(1, 9, 0, 0, 5, 0, 1);
    step(1, 0, 5, 1, 6, 0, 1);
    step(1, 0, 5, 1, 6, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 1);

    // Store waiting on memory, with a flush arriving mid-freeze.
    step(1, 10, 0, 0, 0, 0, 1);
    step(1, 2, 1, 1, 7, 0, 1);
    step(1, 3, 0, 0, 8, 0, 0);
    step(1, 3, 0, 0, 8, 1, 0);
    step(1, 3, 0, 0, 8, 0, 0);
    step(1, 3, 0, 0, 8, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 1);

    // Illegal opcode travels as nothing.
    step(1, 13, 0, 0, 9, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 1);

    // Asynchronous reset with a load frozen in MEM.
    step(1, 9, 0, 0, 5, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    id_valid = 0; flush = 0; mem_ready = 0;
    #1;
    check_val("frozen_before_rst", stall, 1);
    rst = 1'b1;
    #1;
    check_val("arst_stall", stall, 0);
    check_val("arst_ex_aluop", ex_aluop, 0);
    check_val("arst_ex_ri", ex_ri, 0);
    check_val("arst_mem_wme", mem_wme, 0);
    check_val("arst_mem_mm", mem_mm, 0);
    check_val("arst_wb_wre", wb_wre, 0);
    check_val("arst_wb_rd", wb_rd, 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1, 2, 0, 0, 3, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 1);

    // Random traffic; a stalled instruction is held in ID like real fetch would.
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        v = ($urandom_range(0, 9) != 0);
        r = $urandom_range(0, 15);
        if (r < 4)      op = 9;
        else if (r < 6) op = 10;
        else            op = $urandom_range(0, 15);
        rs1 = $urandom_range(0, 3);
        rs2 = $urandom_range(0, 3);
        rd  = $urandom_range(0, 3);
      end
      fl = ($urandom_range(0, 9) == 0);
      mr = ($urandom_range(0, 9) < 6);
      step(v, op, rs1, rs2, rd, fl, mr);
    end

    @(negedge clk);
    check_regs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
